// File: rtl/ctu_ddr_dll_init_seq.sv
// ctu_ddr_dll_init_seq
// Bring-up and supervision sequencer for one DDR channel's master IO DLL.
// The sequencer holds the DLL in reset, waits for lock, and then checks that
// lock stays high for a number of cycles. It retries on timeout or overflow,
// up to a fixed budget. After lock it keeps watching for lock loss or overflow.
// The lock and overflow inputs are asynchronous and pass through 2-flop
// synchronizers. Every decision uses only the synchronized copies.
module ctu_ddr_dll_init_seq #(
    parameter int unsigned RST_HOLD_CYC = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 13
) (
    input  logic       rclk,
    input  logic       arst_l,
    input  logic       start,
    input  logic [2:0] delayctr_cfg,
    output logic       ctu_ddr_iodll_rst_l,
    output logic [2:0] ctu_ddr_dll_delayctr,
    input  logic       ddr_ctu_dll_lock,
    input  logic       ddr_ctu_dll_overflow,
    output logic       dll_ready,
    output logic       dll_fail,
    output logic       lock_lost,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_QUALIFY   = 3'd3,
        S_LOCKED    = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    // One shared counter serves three purposes:
    //   - counts down during the reset hold,
    //   - counts up toward the lock timeout,
    //   - counts up the stable-lock run.
    localparam logic [CNT_W-1:0] CNT_RST_LOAD = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [2:0]       delayctr_q, delayctr_d;
    logic             rst_l_q, rst_l_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
    logic             ovf_meta_q, ovf_meta_d, ovf_s_q, ovf_s_d;
    logic             do_retry;

    // Synchronizer next values: raw pad inputs shift through two stages
    always_comb begin
        lock_meta_d = ddr_ctu_dll_lock;
        lock_s_d    = lock_meta_q;
        ovf_meta_d  = ddr_ctu_dll_overflow;
        ovf_s_d     = ovf_meta_q;
    end

    // Synchronizer flops for the asynchronous lock and overflow inputs
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            ovf_meta_q  <= 1'b0;
            ovf_s_q     <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            ovf_meta_q  <= ovf_meta_d;
            ovf_s_q     <= ovf_s_d;
        end
    end

    // Next-state, counter and retry logic. The registered outputs are derived
    // from the next state, so they line up with the state register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        delayctr_d  = delayctr_q;
        lock_lost_d = 1'b0;
        do_retry    = 1'b0;

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start) begin
                    state_d    = S_RESET;
                    cnt_d      = CNT_RST_LOAD;
                    retry_d    = 2'd0;
                    delayctr_d = delayctr_cfg;
                end
            end
            S_RESET: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the timeout
                if (ovf_s_q) begin
                    do_retry = 1'b1;
                end else if (lock_s_q) begin
                    state_d = S_QUALIFY;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TMO_LAST) begin
                    do_retry = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_QUALIFY: begin
                if (ovf_s_q) begin
                    do_retry = 1'b1;
                end else if (!lock_s_q) begin
                    // Lock dropped while qualifying: the timeout starts again
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_STB_LAST) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LOCKED: begin
                if (!lock_s_q || ovf_s_q) begin
                    lock_lost_d = 1'b1;
                    do_retry    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The retry budget is shared by all failure causes and only a start
        // clears it
        if (do_retry) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 2'd1;
                cnt_d   = CNT_RST_LOAD;
                state_d = S_RESET;
            end else begin
                state_d = S_FAIL;
                cnt_d   = '0;
            end
        end

        rst_l_d = (state_d == S_WAIT_LOCK) || (state_d == S_QUALIFY) ||
                  (state_d == S_LOCKED);
        ready_d = (state_d == S_LOCKED);
        fail_d  = (state_d == S_FAIL);
    end

    // Sequencer state, counter and registered status/control outputs
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            delayctr_q  <= 3'b000;
            rst_l_q     <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            delayctr_q  <= delayctr_d;
            rst_l_q     <= rst_l_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign ctu_ddr_iodll_rst_l  = rst_l_q;
    assign ctu_ddr_dll_delayctr = delayctr_q;
    assign dll_ready            = ready_q;
    assign dll_fail             = fail_q;
    assign lock_lost            = lock_lost_q;
    assign retry_cnt            = retry_q;
    assign seq_state            = state_q;

endmodule

// File: tb/tb_ctu_ddr_dll_init_seq.sv
// Testbench for ctu_ddr_dll_init_seq.
// A cycle-level behavioural model checks every output on every cycle.
// Directed scenarios pin exact cycle positions with literal expectations.
// A randomized phase exercises arbitrary lock, overflow, start and reset
// sequences.
module tb_ctu_ddr_dll_init_seq;

    localparam int RH = 64;
    localparam int LT = 4096;
    localparam int LS = 16;
    localparam int MR = 3;

    localparam int P_IDLE   = 0;
    localparam int P_RESET  = 1;
    localparam int P_WAIT   = 2;
    localparam int P_QUAL   = 3;
    localparam int P_LOCKED = 4;
    localparam int P_FAIL   = 5;

    logic       rclk = 1'b0;
    logic       arst_l = 1'b0;
    logic       start = 1'b0;
    logic [2:0] delayctr_cfg = 3'd0;
    logic       lock_raw = 1'b0;
    logic       ovf_raw = 1'b0;
    logic       ctu_ddr_iodll_rst_l;
    logic [2:0] ctu_ddr_dll_delayctr;
    logic       dll_ready;
    logic       dll_fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    ctu_ddr_dll_init_seq #(
        .RST_HOLD_CYC (RH),
        .LOCK_TIMEOUT (LT),
        .LOCK_STABLE  (LS),
        .MAX_RETRY    (MR),
        .CNT_W        (13)
    ) dut (
        .rclk                 (rclk),
        .arst_l               (arst_l),
        .start                (start),
        .delayctr_cfg         (delayctr_cfg),
        .ctu_ddr_iodll_rst_l  (ctu_ddr_iodll_rst_l),
        .ctu_ddr_dll_delayctr (ctu_ddr_dll_delayctr),
        .ddr_ctu_dll_lock     (lock_raw),
        .ddr_ctu_dll_overflow (ovf_raw),
        .dll_ready            (dll_ready),
        .dll_fail             (dll_fail),
        .lock_lost            (lock_lost),
        .retry_cnt            (retry_cnt),
        .seq_state            (seq_state)
    );

    always #5 rclk = ~rclk;

    // Inputs as seen by the design at each rising edge
    logic       s_rstn = 1'b0;
    logic       s_start = 1'b0;
    logic [2:0] s_cfg = 3'd0;
    logic       s_lock = 1'b0;
    logic       s_ovf = 1'b0;

    always @(posedge rclk) begin
        s_rstn  <= arst_l;
        s_start <= start;
        s_cfg   <= delayctr_cfg;
        s_lock  <= lock_raw;
        s_ovf   <= ovf_raw;
    end

    // Reference model: it is advanced once per cycle from the edge-sampled
    // inputs, and every output is then compared.
    initial begin : model
        int         ph;
        int         age;
        int         retries;
        bit         lost;
        logic [2:0] dly;
        bit         lock_hist [2];
        bit         ovf_hist [2];
        bit         ls, os, rt;
        logic [12:0] expv, actv;
        ph = P_IDLE; age = 0; retries = 0; lost = 0; dly = 3'd0;
        lock_hist[0] = 0; lock_hist[1] = 0; ovf_hist[0] = 0; ovf_hist[1] = 0;
        forever begin
            @(negedge rclk);
            if (s_rstn !== 1'b1) begin
                ph = P_IDLE; age = 0; retries = 0; lost = 0; dly = 3'd0;
                lock_hist[0] = 0; lock_hist[1] = 0;
                ovf_hist[0] = 0; ovf_hist[1] = 0;
            end else begin
                // The synchronized view is the raw sample from two edges ago
                ls = lock_hist[1];
                os = ovf_hist[1];
                rt = 0;
                lost = 0;
                case (ph)
                    P_IDLE, P_FAIL: begin
                        if (s_start) begin
                            ph = P_RESET; age = 0; retries = 0; dly = s_cfg;
                        end
                    end
                    P_RESET: begin
                        if (age == RH - 1) begin ph = P_WAIT; age = 0; end
                        else age++;
                    end
                    P_WAIT: begin
                        if (os) rt = 1;
                        else if (ls) begin ph = P_QUAL; age = 0; end
                        else if (age == LT - 1) rt = 1;
                        else age++;
                    end
                    P_QUAL: begin
                        if (os) rt = 1;
                        else if (!ls) begin ph = P_WAIT; age = 0; end
                        else if (age == LS - 1) begin ph = P_LOCKED; age = 0; end
                        else age++;
                    end
                    P_LOCKED: begin
                        if (!ls || os) begin lost = 1; rt = 1; end
                    end
                    default: ph = P_IDLE;
                endcase
                if (rt) begin
                    if (retries < MR) begin retries++; ph = P_RESET; age = 0; end
                    else begin ph = P_FAIL; age = 0; end
                end
                lock_hist[1] = lock_hist[0]; lock_hist[0] = s_lock;
                ovf_hist[1]  = ovf_hist[0];  ovf_hist[0]  = s_ovf;
            end
            expv = {(ph == P_WAIT || ph == P_QUAL || ph == P_LOCKED), dly,
                    (ph == P_LOCKED), (ph == P_FAIL), lost, 2'(retries), 3'(ph)};
            actv = {ctu_ddr_iodll_rst_l, ctu_ddr_dll_delayctr, dll_ready, dll_fail,
                    lock_lost, retry_cnt, seq_state};
            if (chk_en) begin
                n_tests++;
                if (actv !== expv) begin
                    n_fail++;
                    $display("FAIL model_cmp @%0t: got rst_l=%b dly=%0d rdy=%b fail=%b lost=%b rc=%0d st=%0d, expected rst_l=%b dly=%0d rdy=%b fail=%b lost=%b rc=%0d st=%0d",
                             $time, actv[12], actv[11:9], actv[8], actv[7], actv[6], actv[5:4], actv[3:0] & 4'h7,
                             expv[12], expv[11:9], expv[8], expv[7], expv[6], expv[5:4], expv[3:0] & 4'h7);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge rclk);
        arst_l = 1'b0; start = 1'b0; lock_raw = 1'b0; ovf_raw = 1'b0;
        repeat (2) @(negedge rclk);
        arst_l = 1'b1;
    endtask

    task automatic kick(input logic [2:0] c);
        @(negedge rclk);
        start = 1'b1;
        delayctr_cfg = c;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(seq_state), P_IDLE);
        chk({tag, "_rst_l"}, int'(ctu_ddr_iodll_rst_l), 0);
        chk({tag, "_dly"},   int'(ctu_ddr_dll_delayctr), 0);
        chk({tag, "_ready"}, int'(dll_ready), 0);
        chk({tag, "_fail"},  int'(dll_fail), 0);
        chk({tag, "_lost"},  int'(lock_lost), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    initial begin : driver
        arst_l = 1'b0;
        repeat (3) @(negedge rclk);
        chk_reset_outputs("por");
        chk_en = 1'b1;
        arst_l = 1'b1;

        // Nominal bring-up, then overflow in LOCKED, then lock drop in LOCKED
        kick(3'b101);
        for (int k = 1; k <= 340; k++) begin
            @(negedge rclk);
            if (k == 1) begin
                start = 1'b0;
                chk("nom_dly_c1", int'(ctu_ddr_dll_delayctr), 5);
                chk("nom_rst_l_c1", int'(ctu_ddr_iodll_rst_l), 0);
                chk("nom_state_c1", int'(seq_state), P_RESET);
            end
            if (k == 2) delayctr_cfg = 3'b010;
            if (k == 64) chk("nom_rst_l_c64", int'(ctu_ddr_iodll_rst_l), 0);
            if (k == 65) begin
                chk("nom_rst_l_c65", int'(ctu_ddr_iodll_rst_l), 1);
                chk("nom_state_c65", int'(seq_state), P_WAIT);
            end
            if (k == 199) lock_raw = 1'b1;
            if (k == 201) chk("nom_state_c201", int'(seq_state), P_WAIT);
            if (k == 202) chk("nom_state_c202", int'(seq_state), P_QUAL);
            if (k == 217) chk("nom_ready_c217", int'(dll_ready), 0);
            if (k == 218) begin
                chk("nom_ready_c218", int'(dll_ready), 1);
                chk("nom_retry_c218", int'(retry_cnt), 0);
                chk("nom_dly_c218", int'(ctu_ddr_dll_delayctr), 5);
            end
            if (k == 230) ovf_raw = 1'b1;
            if (k == 231) ovf_raw = 1'b0;
            if (k == 232) chk("ovf_lost_c232", int'(lock_lost), 0);
            if (k == 233) begin
                chk("ovf_lost_c233", int'(lock_lost), 1);
                chk("ovf_ready_c233", int'(dll_ready), 0);
                chk("ovf_rst_l_c233", int'(ctu_ddr_iodll_rst_l), 0);
                chk("ovf_retry_c233", int'(retry_cnt), 1);
            end
            if (k == 234) chk("ovf_lost_c234", int'(lock_lost), 0);
            if (k == 296) chk("ovf_rst_l_c296", int'(ctu_ddr_iodll_rst_l), 0);
            if (k == 297) chk("ovf_rst_l_c297", int'(ctu_ddr_iodll_rst_l), 1);
            if (k == 314) chk("relock_ready_c314", int'(dll_ready), 1);
            if (k == 320) lock_raw = 1'b0;
            if (k == 322) chk("drop_state_c322", int'(seq_state), P_LOCKED);
            if (k == 323) begin
                chk("drop_lost_c323", int'(lock_lost), 1);
                chk("drop_retry_c323", int'(retry_cnt), 2);
                chk("drop_state_c323", int'(seq_state), P_RESET);
            end
        end

        // Qualify glitch, followed by an asynchronous reset while LOCKED
        do_reset();
        kick(3'b001);
        for (int k = 1; k <= 235; k++) begin
            @(negedge rclk);
            if (k == 1) start = 1'b0;
            if (k == 199) lock_raw = 1'b1;
            if (k == 209) lock_raw = 1'b0;
            if (k == 210) lock_raw = 1'b1;
            if (k == 211) chk("glitch_state_c211", int'(seq_state), P_QUAL);
            if (k == 212) chk("glitch_state_c212", int'(seq_state), P_WAIT);
            if (k == 213) chk("glitch_state_c213", int'(seq_state), P_QUAL);
            if (k == 228) chk("glitch_ready_c228", int'(dll_ready), 0);
            if (k == 229) begin
                chk("glitch_ready_c229", int'(dll_ready), 1);
                chk("glitch_retry_c229", int'(retry_cnt), 0);
            end
        end
        #2 arst_l = 1'b0;
        #1 chk_reset_outputs("arst_locked");
        @(negedge rclk);
        arst_l = 1'b1;

        // Timeout exhaustion, with a start ignored in WAIT_LOCK and a restart from FAIL
        do_reset();
        kick(3'b011);
        for (int k = 1; k <= 16646; k++) begin
            @(negedge rclk);
            if (k == 1) start = 1'b0;
            if (k == 100) begin start = 1'b1; delayctr_cfg = 3'b110; end
            if (k == 101) begin
                start = 1'b0;
                chk("ign_state_c101", int'(seq_state), P_WAIT);
                chk("ign_dly_c101", int'(ctu_ddr_dll_delayctr), 3);
            end
            if (k == 4160) chk("tmo_state_c4160", int'(seq_state), P_WAIT);
            if (k == 4161) chk("tmo_retry_c4161", int'(retry_cnt), 1);
            if (k == 8321) chk("tmo_retry_c8321", int'(retry_cnt), 2);
            if (k == 12481) chk("tmo_retry_c12481", int'(retry_cnt), 3);
            if (k == 16640) chk("tmo_state_c16640", int'(seq_state), P_WAIT);
            if (k == 16641) begin
                chk("tmo_state_c16641", int'(seq_state), P_FAIL);
                chk("tmo_fail_c16641", int'(dll_fail), 1);
                chk("tmo_rst_l_c16641", int'(ctu_ddr_iodll_rst_l), 0);
            end
            if (k == 16645) begin start = 1'b1; delayctr_cfg = 3'b100; end
            if (k == 16646) begin
                start = 1'b0;
                chk("restart_state", int'(seq_state), P_RESET);
                chk("restart_retry", int'(retry_cnt), 0);
                chk("restart_fail", int'(dll_fail), 0);
                chk("restart_dly", int'(ctu_ddr_dll_delayctr), 4);
            end
        end

        // Lock arriving on the timeout cycle; overflow together with lock in WAIT_LOCK
        do_reset();
        kick(3'b111);
        for (int k = 1; k <= 4245; k++) begin
            @(negedge rclk);
            if (k == 1) start = 1'b0;
            if (k == 4158) lock_raw = 1'b1;
            if (k == 4161) begin
                chk("sim_state_c4161", int'(seq_state), P_QUAL);
                chk("sim_retry_c4161", int'(retry_cnt), 0);
            end
            if (k == 4170) ovf_raw = 1'b1;
            if (k == 4171) ovf_raw = 1'b0;
            if (k == 4173) chk("qovf_retry_c4173", int'(retry_cnt), 1);
            if (k == 4200) lock_raw = 1'b0;
            if (k == 4240) begin lock_raw = 1'b1; ovf_raw = 1'b1; end
            if (k == 4241) ovf_raw = 1'b0;
            if (k == 4242) chk("wovf_state_c4242", int'(seq_state), P_WAIT);
            if (k == 4243) begin
                chk("wovf_state_c4243", int'(seq_state), P_RESET);
                chk("wovf_retry_c4243", int'(retry_cnt), 2);
            end
        end

        // Randomized traffic, checked by the model every cycle
        do_reset();
        for (int k = 0; k < 20000; k++) begin
            @(negedge rclk);
            start = ($urandom_range(0, 149) == 0);
            delayctr_cfg = 3'($urandom);
            if ($urandom_range(0, 99) < 3) lock_raw = ~lock_raw;
            ovf_raw = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 4999) == 0) begin
                #2 arst_l = 1'b0;
                @(negedge rclk);
                arst_l = 1'b1;
            end
        end

        @(negedge rclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
